// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared state encoding, bus-width constants and counter sizing for lcd_bus_8080.
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        RST_LO,
        RST_WT,
        IDLE,
        WR_LO,
        WR_HI,
        RD_LO,
        RD_HI
    } state_t;

    localparam int BUS_W8  = 8;
    localparam int BUS_W16 = 16;

    function automatic int cnt_w(input int a, input int b, input int c,
                                 input int d, input int e, input int f);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        m = (e > m) ? e : m;
        m = (f > m) ? f : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_bus_8080.sv
// lcd_bus_8080: 8080-style panel bus master with power-up reset sequencing,
// timed WR_/RD_ strobes and two-beat 16-bit words on an 8-bit bus.
module lcd_bus_8080
    import lcd_bus_pkg::*;
#(
    parameter int BUS_W    = 8,
    parameter int WR_LOW   = 1,
    parameter int WR_HIGH  = 1,
    parameter int RD_LOW   = 16,
    parameter int RD_HIGH  = 10,
    parameter int RST_LOW  = 400,
    parameter int RST_WAIT = 4_500_000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_rs,
    input  logic             i_rd,
    input  logic             i_wide,
    input  logic [15:0]      i_data,
    output logic [15:0]      o_rdata,
    output logic             o_rvalid,
    output logic             o_init_done,
    output logic [BUS_W-1:0] o_lcd_data,
    output logic             o_lcd_oe,
    input  logic [BUS_W-1:0] i_lcd_data,
    output logic             o_lcd_rs,
    output logic             o_lcd_wr_n,
    output logic             o_lcd_rd_n,
    output logic             o_lcd_cs_n,
    output logic             o_lcd_rst_n
);

    localparam int CW = cnt_w(WR_LOW, WR_HIGH, RD_LOW, RD_HIGH, RST_LOW, RST_WAIT);
    localparam bit NARROW = (BUS_W == BUS_W8);

    if (!(BUS_W == BUS_W8 || BUS_W == BUS_W16) || WR_LOW < 1 || WR_HIGH < 1 ||
        RD_LOW < 1 || RD_HIGH < 1 || RST_LOW < 1 || RST_WAIT < 1) begin : g_bad_param
        $error("lcd_bus_8080: BUS_W must be 8 or 16 and all timing parameters >= 1");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          beat_left;
    logic [7:0]    lo_byte;
    logic          wide8;

    assign o_ready = (state == IDLE);
    assign wide8   = NARROW && i_wide;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= RST_LO;
            cnt         <= CW'(RST_LOW - 1);
            beat_left   <= 1'b0;
            lo_byte     <= '0;
            o_lcd_rst_n <= 1'b0;
            o_lcd_cs_n  <= 1'b1;
            o_lcd_wr_n  <= 1'b1;
            o_lcd_rd_n  <= 1'b1;
            o_lcd_rs    <= 1'b0;
            o_lcd_data  <= '0;
            o_lcd_oe    <= 1'b1;
            o_rvalid    <= 1'b0;
            o_rdata     <= '0;
            o_init_done <= 1'b0;
        end else begin
            o_rvalid <= 1'b0;
            if (cnt != '0) cnt <= cnt - 1'b1;
            case (state)
                RST_LO: if (cnt == '0) begin
                    state       <= RST_WT;
                    cnt         <= CW'(RST_WAIT - 1);
                    o_lcd_rst_n <= 1'b1;
                end
                RST_WT: if (cnt == '0) begin
                    state       <= IDLE;
                    o_lcd_cs_n  <= 1'b0;
                    o_init_done <= 1'b1;
                end
                IDLE: if (i_valid) begin
                    o_lcd_rs  <= i_rs;
                    lo_byte   <= i_data[7:0];
                    beat_left <= wide8;
                    if (i_rd) begin
                        state      <= RD_LO;
                        cnt        <= CW'(RD_LOW - 1);
                        o_lcd_rd_n <= 1'b0;
                        o_lcd_oe   <= 1'b0;
                        o_rdata    <= '0;
                    end else begin
                        state      <= WR_LO;
                        cnt        <= CW'(WR_LOW - 1);
                        o_lcd_wr_n <= 1'b0;
                        o_lcd_data <= wide8 ? BUS_W'(i_data[15:8]) : i_data[BUS_W-1:0];
                    end
                end
                WR_LO: if (cnt == '0) begin
                    state      <= WR_HI;
                    cnt        <= CW'(WR_HIGH - 1);
                    o_lcd_wr_n <= 1'b1;
                end
                WR_HI: if (cnt == '0) begin
                    if (beat_left) begin
                        beat_left  <= 1'b0;
                        state      <= WR_LO;
                        cnt        <= CW'(WR_LOW - 1);
                        o_lcd_wr_n <= 1'b0;
                        o_lcd_data <= BUS_W'(lo_byte);
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_LO: if (cnt == '0) begin
                    state      <= RD_HI;
                    cnt        <= CW'(RD_HIGH - 1);
                    o_lcd_rd_n <= 1'b1;
                    // narrow reads shift into a cleared word, wide reads build {beat1, beat2}
                    o_rdata    <= (BUS_W == BUS_W16) ? 16'(i_lcd_data) : {o_rdata[7:0], i_lcd_data[7:0]};
                    o_rvalid   <= !beat_left && (RD_HIGH == 1);
                end
                RD_HI: begin
                    if (cnt == CW'(1) && !beat_left) o_rvalid <= 1'b1;
                    if (cnt == '0) begin
                        if (beat_left) begin
                            beat_left  <= 1'b0;
                            state      <= RD_LO;
                            cnt        <= CW'(RD_LOW - 1);
                            o_lcd_rd_n <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            o_lcd_oe <= 1'b1;
                        end
                    end
                end
                default: state <= RST_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_8080.sv
// tb_lcd_bus_8080: directed and randomized checks of lcd_bus_8080 against a cycle-level timing model.
module tb_lcd_bus_8080;

    localparam int WL  = 2;
    localparam int WH  = 1;
    localparam int RL  = 3;
    localparam int RH  = 2;
    localparam int RSL = 4;
    localparam int RSW = 8;

    logic        clk = 0;
    logic        reset = 1;
    logic        valid = 0, valid16 = 0;
    logic        rs_in = 0, rd_in = 0, wide_in = 0;
    logic [15:0] din = 0;

    logic        ready, rvalid, init_done, oe, rs, wr_n, rd_n, cs_n, rst_n;
    logic [15:0] rdata;
    logic [7:0]  lcd_data, bus8;
    logic        ready16, rvalid16, init16, oe16, rs16, wr16, rd16, cs16, rst16;
    logic [15:0] rdata16, data16, bus16 = 0;

    logic [7:0]  b1 = 0, b2 = 0;
    int          rd_rises = 0, base = 0, overlap = 0, ptr = 0;
    logic        pw = 1, pr = 1;
    logic [8:0]  cap[$];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    lcd_bus_8080 #(.BUS_W(8), .WR_LOW(WL), .WR_HIGH(WH), .RD_LOW(RL), .RD_HIGH(RH),
                   .RST_LOW(RSL), .RST_WAIT(RSW)) u8 (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .o_ready(ready),
        .i_rs(rs_in), .i_rd(rd_in), .i_wide(wide_in), .i_data(din),
        .o_rdata(rdata), .o_rvalid(rvalid), .o_init_done(init_done),
        .o_lcd_data(lcd_data), .o_lcd_oe(oe), .i_lcd_data(bus8),
        .o_lcd_rs(rs), .o_lcd_wr_n(wr_n), .o_lcd_rd_n(rd_n),
        .o_lcd_cs_n(cs_n), .o_lcd_rst_n(rst_n)
    );

    lcd_bus_8080 #(.BUS_W(16), .WR_LOW(WL), .WR_HIGH(WH), .RD_LOW(RL), .RD_HIGH(RH),
                   .RST_LOW(RSL), .RST_WAIT(RSW)) u16 (
        .i_clk(clk), .i_reset(reset), .i_valid(valid16), .o_ready(ready16),
        .i_rs(rs_in), .i_rd(rd_in), .i_wide(wide_in), .i_data(din),
        .o_rdata(rdata16), .o_rvalid(rvalid16), .o_init_done(init16),
        .o_lcd_data(data16), .o_lcd_oe(oe16), .i_lcd_data(bus16),
        .o_lcd_rs(rs16), .o_lcd_wr_n(wr16), .o_lcd_rd_n(rd16),
        .o_lcd_cs_n(cs16), .o_lcd_rst_n(rst16)
    );

    // Panel model: returns b1 for the first read beat of a transfer, b2 afterwards.
    assign bus8 = (rd_rises == base) ? b1 : b2;

    always @(negedge clk) begin
        pw <= wr_n;
        pr <= rd_n;
        if (pw === 1'b0 && wr_n === 1'b1) cap.push_back({rs, lcd_data});
        if (pr === 1'b0 && rd_n === 1'b1) rd_rises <= rd_rises + 1;
        if (wr_n === 1'b0 && rd_n === 1'b0) overlap <= overlap + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic power_up();
        reset = 1; valid = 0; valid16 = 0;
        repeat (3) @(negedge clk);
        check("rst_rst_n", rst_n, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_rs", rs, 0);
        check("rst_data", lcd_data, 0);
        check("rst_oe", oe, 1);
        check("rst_ready", ready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_init", init_done, 0);
        reset = 0;
        #1;
        check("first_rst_n", rst_n, 0);
        check("first_ready", ready, 0);
        for (int j = 1; j <= RSL + RSW; j++) begin
            @(negedge clk);
            check("pu_rst_n", rst_n, j >= RSL);
            check("pu_cs_n", cs_n, j < RSL + RSW);
            check("pu_init", init_done, j >= RSL + RSW);
            check("pu_ready", ready, j >= RSL + RSW);
            check("pu_ready16", ready16, j >= RSL + RSW);
        end
        ptr = cap.size();
    endtask

    task automatic xfer(input bit rd, input bit wide, input bit rsv, input logic [15:0] d, input bit cont);
        int t, beats, lo, per, dur, ph, bt;
        logic [15:0] exp_rd;
        logic [7:0] eb;
        t = 0;
        while (ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        check("ready_wait", ready, 1);
        beats = wide ? 2 : 1;
        lo = rd ? RL : WL;
        per = rd ? RL + RH : WL + WH;
        dur = beats * per;
        if (rd) begin b1 = 8'($urandom); b2 = 8'($urandom); base = rd_rises; end
        exp_rd = wide ? {b1, b2} : {8'h00, b1};
        valid = 1; rd_in = rd; wide_in = wide; rs_in = rsv; din = d;
        @(posedge clk);
        @(negedge clk);
        valid = cont; rd_in = 1'($urandom); wide_in = 1'($urandom); rs_in = 1'($urandom); din = 16'($urandom);
        for (int k = 1; k <= dur + 1; k++) begin
            if (k > 1) @(negedge clk);
            ph = (k - 1) % per;
            bt = (k - 1) / per;
            check("ready", ready, k > dur);
            check("wr_n", wr_n, (!rd && k <= dur) ? (ph >= lo) : 1);
            check("rd_n", rd_n, (rd && k <= dur) ? (ph >= lo) : 1);
            check("oe", oe, !(rd && k <= dur));
            check("rs", rs, rsv);
            check("rvalid", rvalid, rd && k == dur);
            if (rd && k == dur) check("rdata", rdata, exp_rd);
            eb = (bt == 0 && wide) ? d[15:8] : d[7:0];
            if (!rd && k <= dur) check("wdata", lcd_data, eb);
        end
        if (!rd) begin
            check("beats", cap.size() - ptr, beats);
            for (int b = 0; b < beats; b++) begin
                eb = (b == 0 && wide) ? d[15:8] : d[7:0];
                if (ptr < cap.size()) begin
                    check("latched", cap[ptr], {rsv, eb});
                    ptr++;
                end
            end
        end
    endtask

    initial begin
        power_up();

        xfer(0, 0, 0, 16'h002C, 0);
        xfer(0, 0, 1, 16'h00A5, 0);
        xfer(0, 1, 1, 16'hF81F, 0);

        @(negedge clk);
        b1 = 8'h93; b2 = 8'h41; base = rd_rises;
        valid = 1; rd_in = 1; wide_in = 1; rs_in = 1; din = 0;
        @(posedge clk);
        @(negedge clk);
        valid = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            check("wr_oe", oe, k > 10);
            check("wr_rvalid", rvalid, k == 10);
            if (k == 10) check("wr_rdata", rdata, 16'h9341);
        end

        xfer(1, 0, 0, 16'h0000, 0);
        xfer(1, 1, 1, 16'h0000, 0);

        // 16-bit bus: one beat per word, wide flag ignored
        @(negedge clk);
        valid16 = 1; rd_in = 0; wide_in = 1; rs_in = 1; din = 16'hF81F;
        @(posedge clk);
        @(negedge clk);
        valid16 = 0; din = 16'h1234;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            check("w16_ready", ready16, k == 4);
            check("w16_wr_n", wr16, k >= 3);
            if (k <= 3) check("w16_data", data16, 16'hF81F);
        end
        bus16 = 16'($urandom);
        valid16 = 1; rd_in = 1; wide_in = 1;
        @(posedge clk);
        @(negedge clk);
        valid16 = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            check("r16_rd_n", rd16, k > 3);
            check("r16_oe", oe16, k == 6);
            check("r16_rvalid", rvalid16, k == 5);
            check("r16_ready", ready16, k == 6);
            if (k == 5) check("r16_rdata", rdata16, bus16);
        end

        // abandon a write while WR_ is low
        valid = 1; rd_in = 0; wide_in = 1; rs_in = 1; din = 16'h5AA5;
        @(posedge clk);
        @(negedge clk);
        valid = 0;
        check("mid_wr_low", wr_n, 0);
        reset = 1;
        @(negedge clk);
        check("mid_wr_n", wr_n, 1);
        check("mid_cs_n", cs_n, 1);
        check("mid_rst_n", rst_n, 0);
        check("mid_ready", ready, 0);
        check("mid_init", init_done, 0);
        power_up();

        for (int i = 0; i < 1000; i++)
            xfer(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1);
        valid = 0;

        check("no_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
